// File: rtl/mod_p_reduce_hs.sv
// Sequential restoring shift-subtract reduction of a W-bit operand modulo P.
// Retires BPC operand bits per clock; valid/ready handshake on both sides.

module mod_p_reduce_step #(
  parameter int           N = 256,
  parameter logic [N-1:0] P = '1
) (
  input  logic [N-1:0] i_r,
  input  logic         i_bit,
  output logic [N-1:0] o_r
);
  // One extra bit keeps the shifted remainder exact before the conditional subtract
  logic [N:0] w_sh;
  assign w_sh = {i_r, i_bit};
  assign o_r  = (w_sh >= {1'b0, P}) ? N'(w_sh - {1'b0, P}) : N'(w_sh);
endmodule

module mod_p_reduce_hs #(
  parameter int           N   = 256,
  parameter int           W   = 512,
  parameter int           BPC = 4,
  parameter logic [N-1:0] P   = (N'(1) << 255) - N'(19)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_rem,
  output logic         busy
);
  localparam int STEPS = W / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (P == '0 || P >= (N'(1) << (N-1))) begin : g_bad_p
    $error("mod_p_reduce_hs: P must satisfy 0 < P < 2^(N-1)");
  end
  if (BPC < 1 || BPC > 16 || (W % BPC) != 0) begin : g_bad_bpc
    $error("mod_p_reduce_hs: BPC must be 1..16 and divide W");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state, w_nxt;
  logic [N-1:0]        r_rem;
  logic [W-1:0]        r_opnd;
  logic [CW-1:0]       r_cnt;
  logic                w_last;
  logic [BPC:0][N-1:0] w_chain;

  assign w_last     = (r_cnt == CW'(STEPS - 1));
  assign w_chain[0] = r_rem;

  // Unrolled chain: stage b consumes the b-th operand bit below the MSB
  for (genvar b = 0; b < BPC; b++) begin : g_step
    mod_p_reduce_step #(.N(N), .P(P)) u_step (
      .i_r   (w_chain[b]),
      .i_bit (r_opnd[W-1-b]),
      .o_r   (w_chain[b+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_nxt = S_BUSY;
      S_BUSY:  if (w_last)    w_nxt = S_DONE;
      S_DONE:  if (out_ready) w_nxt = S_IDLE;
      default:                w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_rem  <= '0;
          r_opnd <= in_data;
          r_cnt  <= '0;
        end
        S_BUSY: begin
          r_rem  <= w_chain[BPC];
          r_opnd <= r_opnd << BPC;
          r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_rem = r_rem;
endmodule
